load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Execute-to-memory stage directly downstream of the ALU.
- Consumes the ALU result as the effective address, or as a pass-through result for non-memory ops, plus the rs2 store data.
- Runs a request/grant/response transaction to data memory, with byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
- Presents a registered writeback result and back-pressures execute while a transaction is in flight.

Parameters:
- DATA_WIDTH, 32, datapath width. Fixed at 32; 4 byte lanes.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute presents an op
- ex_ready  out  1  stage can accept; equals (state==IDLE)
- MemRead  in  1  op is a load
- MemWrite  in  1  op is a store
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUout  in  ADDR_WIDTH  effective address or pass-through result
- WriteData  in  DATA_WIDTH  store data (rs2)
- rd_in  in  5  destination register
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word-aligned address, {ALUout[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read word
- wb_valid  out  1  one-cycle pulse, writeback valid
- wb_data  out  DATA_WIDTH  writeback value
- wb_rd  out  5  writeback register
- store_done  out  1  one-cycle pulse, store granted
- fault  out  1  one-cycle pulse, misaligned or illegal op

Behaviour:
- Reset:
  - Async assert sets state=IDLE and clears every output register to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_data, wb_rd, store_done, fault.
  - Reset mid-transaction abandons the transaction; any late mem_gnt or mem_rvalid is ignored.
- FSM states: IDLE, REQ, WAIT_R.
- Acceptance happens on ex_valid && ex_ready. Op, address, data and rd are latched on acceptance.
- IDLE, accepted, neither MemRead nor MemWrite:
  - Next cycle: wb_valid=1, wb_data=ALUout, wb_rd=rd_in.
  - Stay in IDLE (1-cycle latency).
- IDLE, accepted, fault condition. Any of:
  - MemRead && MemWrite
  - load funct3 in {011,110,111}
  - store funct3 > 010
  - H/HU/SH with addr[0]=1
  - W/SW with addr[1:0]!=0
  - Response: next cycle fault=1 for one cycle, no mem_req, no wb_valid; stay in IDLE.
- IDLE, accepted, valid load/store:
  - Go to REQ.
  - mem_req=1 from the next cycle.
  - mem_addr, mem_we, mem_be, mem_wdata stay stable until the grant cycle.
- REQ:
  - Hold request while mem_gnt=0.
  - On mem_gnt=1, mem_req drops next cycle.
  - Store: store_done=1 next cycle; go to IDLE.
  - Load: go to WAIT_R.
- WAIT_R:
  - On mem_rvalid=1, next cycle wb_valid=1, wb_rd=latched rd, wb_data=extracted value; go to IDLE.
- Protocol rules:
  - mem_rvalid is legal only in WAIT_R; in any other state it is ignored.
  - Memory never asserts mem_rvalid in the same cycle as mem_gnt.
  - No timeout.
- Store lanes:
  - SB: wdata={4{WriteData[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{WriteData[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata=WriteData, be=1111.
  - Loads: be=1111, wdata=0.
- Load extraction: sh = mem_rdata >> (8*addr[1:0]).
  - B: sign-extend sh[7:0]; BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0]; HU: zero-extend sh[15:0].
  - W: mem_rdata unchanged.
- Back-to-back operation:
  - ex_ready is high in the same cycle wb_valid, store_done or fault pulses, so a new op may be accepted there.
  - Minimum store occupancy: 2 cycles with immediate grant. Minimum load occupancy: 3 cycles.
- Inputs are ignored when ex_ready=0; execute holds its op until accepted.

Test Plan:
- Pass-through: ALUout=0x0000_1234, rd_in=5, no mem op -> next cycle wb_valid=1, wb_data=0x0000_1234, wb_rd=5; ex_ready stays 1.
- SB with ALUout=0x103, WriteData=0xAABBCCDD, gnt after 2 wait cycles -> mem_addr=0x100, be=1000, wdata=0xDDDDDDDD held for 3 cycles; store_done pulses once.
- LB at 0x202 then LBU at 0x202, mem_rdata=0x11F07733 -> first wb_data=0xFFFFFFF0, second wb_data=0x000000F0.
- LH at 0x301 and SW at 0x402 -> fault pulses each time; mem_req never asserts; no wb_valid.
- LW, gnt then rvalid 4 cycles later with rdata=0xDEADBEEF -> ex_ready=0 throughout; wb_valid=1 with 0xDEADBEEF; a pass-through op accepted in the same cycle completes one cycle later.
- rst_n pulsed low during WAIT_R, then rvalid arrives -> all outputs 0 immediately, state IDLE, no wb_valid from the stale rvalid.

Source files
------------

// File: rtl/load_store_unit.sv
// Execute-to-memory stage: turns the ALU result into a data-memory transaction (or passes it
// through) and presents a registered writeback, stalling execute while a request is in flight.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] ALUout,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            rd_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [4:0]            wb_rd,
  output logic                  store_done,
  output logic                  fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

  state_e          state;
  logic            is_load_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;

  logic                  fault_c;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [15:0]           ld_shift;
  logic [DATA_WIDTH-1:0] ld_val;

  assign ex_ready = (state == StIdle);

  // Illegal encodings and misalignment are decided on the incoming op, before acceptance.
  always_comb begin
    fault_c = 1'b0;
    if (MemRead && MemWrite) begin
      fault_c = 1'b1;
    end else if (MemRead) begin
      case (funct3)
        3'b000, 3'b100: fault_c = 1'b0;
        3'b001, 3'b101: fault_c = ALUout[0];
        3'b010:         fault_c = |ALUout[1:0];
        default:        fault_c = 1'b1;
      endcase
    end else if (MemWrite) begin
      case (funct3)
        3'b000:  fault_c = 1'b0;
        3'b001:  fault_c = ALUout[0];
        3'b010:  fault_c = |ALUout[1:0];
        default: fault_c = 1'b1;
      endcase
    end
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = '0;
    if (MemWrite) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_c = {4{WriteData[7:0]}};
          be_c    = 4'b0001 << ALUout[1:0];
        end
        2'b01: begin
          wdata_c = {2{WriteData[15:0]}};
          be_c    = ALUout[1] ? 4'b1100 : 4'b0011;
        end
        default: wdata_c = WriteData;
      endcase
    end
  end

  always_comb begin
    ld_shift = 16'(mem_rdata >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_val = {24'b0, ld_shift[7:0]};
      3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_val = {16'b0, ld_shift[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      is_load_q  <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      store_done <= 1'b0;
      fault      <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      store_done <= 1'b0;
      fault      <= 1'b0;
      case (state)
        StIdle: begin
          if (ex_valid) begin
            if (!MemRead && !MemWrite) begin
              wb_valid <= 1'b1;
              wb_data  <= ALUout;
              wb_rd    <= rd_in;
            end else if (fault_c) begin
              fault <= 1'b1;
            end else begin
              state     <= StReq;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {ALUout[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
              is_load_q <= MemRead;
              f3_q      <= funct3;
              off_q     <= ALUout[1:0];
              rd_q      <= rd_in;
            end
          end
        end
        StReq: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (is_load_q) begin
              state <= StWaitR;
            end else begin
              store_done <= 1'b1;
              state      <= StIdle;
            end
          end
        end
        StWaitR: begin
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_data  <= ld_val;
            wb_rd    <= rd_q;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized ops checked
// against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUout, WriteData;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, store_done, fault;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by run_op
  logic        obs_wb_valid, obs_store_done, obs_fault, obs_req_seen, obs_req_after, obs_we;
  logic [31:0] obs_wb_data, obs_addr, obs_wdata;
  logic [4:0]  obs_wb_rd;
  logic [3:0]  obs_be;
  logic        obs_hold_ok, obs_busy_ok, obs_ready_end, obs_extra;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .ALUout(ALUout),
    .WriteData(WriteData), .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .store_done(store_done), .fault(fault)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 pass-through, 1 fault, 2 store, 3 load
  task automatic model(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                       output int kind, output logic [3:0] be, output logic [31:0] wdata,
                       output logic [31:0] lval);
    int  size, off;
    bit  legal;
    off  = int'(addr[1:0]);
    size = 1 << f3[1:0];
    be = '0; wdata = '0; lval = '0;
    if (!mr && !mw) begin
      kind = 0;
    end else begin
      legal = !(mr && mw) && (mr ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                                 : (f3 inside {3'd0, 3'd1, 3'd2}));
      if (legal && (off % size) != 0) legal = 0;
      kind = legal ? (mw ? 2 : 3) : 1;
    end
    if (kind == 2) begin
      for (int i = 0; i < 4; i++) begin
        be[i] = (i >= off) && (i < off + size);
        wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      end
    end else if (kind == 3) begin
      be = 4'hF;
      for (int i = 0; i < size; i++) lval[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (!f3[2] && size < 4 && lval[8*size-1])
        for (int i = size; i < 4; i++) lval[8*i +: 8] = 8'hFF;
    end
  endtask

  // Presents one op in IDLE, plays the memory side, and records what the DUT did.
  task automatic run_op(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int          kind;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_lv;
    model(mr, mw, f3, addr, wd, rdata, kind, e_be, e_wd, e_lv);
    ex_valid = 1'b1; MemRead = mr; MemWrite = mw; funct3 = f3;
    ALUout = addr; WriteData = wd; rd_in = rd;
    tick();
    ex_valid = 1'b0;
    obs_req_seen = mem_req; obs_req_after = 1'b0;
    obs_hold_ok = 1'b1; obs_busy_ok = 1'b1;
    obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
    if (kind >= 2) begin
      for (int d = 0; d <= gnt_dly; d++) begin
        obs_busy_ok &= !ex_ready;
        obs_hold_ok &= mem_req && (mem_addr == obs_addr) && (mem_be == obs_be) &&
                       (mem_wdata == obs_wdata) && (mem_we == obs_we);
        // Junk from execute must be ignored while busy
        ex_valid = 1'($urandom); ALUout = $urandom; MemRead = 1'($urandom);
        if (d == gnt_dly) mem_gnt = 1'b1;
        tick();
      end
      mem_gnt = 1'b0;
      obs_req_after = mem_req;
      if (kind == 3) begin
        for (int d = 0; d <= rv_dly; d++) begin
          obs_busy_ok &= !ex_ready;
          if (d == rv_dly) begin
            ex_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
          end
          tick();
        end
        mem_rvalid = 1'b0;
      end
      ex_valid = 1'b0;
    end
    obs_wb_valid = wb_valid; obs_wb_data = wb_data; obs_wb_rd = wb_rd;
    obs_store_done = store_done; obs_fault = fault; obs_ready_end = ex_ready;
    tick();
    obs_extra = wb_valid | store_done | fault | mem_req;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_data, wb_rd,
         store_done, fault} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero (addr=%h be=%b wb=%h)",
                         mem_addr, mem_be, wb_data);
    end
    n_checks++;
    if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ex_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough;
    run_op(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0);
    n_checks++;
    if (obs_wb_valid !== 1'b1 || obs_wb_data !== 32'h1234 || obs_wb_rd !== 5'd5) begin
      n_fail++; $display("FAIL pass_wb: got v=%b d=%h rd=%0d want 1 00001234 5",
                         obs_wb_valid, obs_wb_data, obs_wb_rd);
    end
    n_checks++;
    if (obs_ready_end !== 1'b1 || obs_req_seen !== 1'b0 || obs_extra !== 1'b0) begin
      n_fail++; $display("FAIL pass_misc: ready=%b req=%b extra=%b want 1 0 0",
                         obs_ready_end, obs_req_seen, obs_extra);
    end
  endtask

  task automatic test_store_byte;
    run_op(0, 1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 2, 0, 32'h0);
    n_checks++;
    if (obs_addr !== 32'h100 || obs_be !== 4'b1000 || obs_wdata !== 32'hDDDD_DDDD ||
        obs_we !== 1'b1) begin
      n_fail++; $display("FAIL sb_req: got a=%h be=%b wd=%h we=%b want 100 1000 dddddddd 1",
                         obs_addr, obs_be, obs_wdata, obs_we);
    end
    n_checks++;
    if (obs_hold_ok !== 1'b1 || obs_busy_ok !== 1'b1) begin
      n_fail++; $display("FAIL sb_hold: hold=%b busy=%b want 1 1", obs_hold_ok, obs_busy_ok);
    end
    n_checks++;
    if (obs_store_done !== 1'b1 || obs_req_after !== 1'b0 || obs_extra !== 1'b0 ||
        obs_wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL sb_done: done=%b req=%b extra=%b wb=%b want 1 0 0 0",
                         obs_store_done, obs_req_after, obs_extra, obs_wb_valid);
    end
  endtask

  task automatic test_load_ext;
    run_op(1, 0, 3'b000, 32'h0000_0202, 32'h0, 5'd7, 0, 1, 32'h11F0_7733);
    n_checks++;
    if (obs_wb_valid !== 1'b1 || obs_wb_data !== 32'hFFFF_FFF0 || obs_wb_rd !== 5'd7) begin
      n_fail++; $display("FAIL lb: got v=%b d=%h rd=%0d want 1 fffffff0 7",
                         obs_wb_valid, obs_wb_data, obs_wb_rd);
    end
    n_checks++;
    if (obs_addr !== 32'h200 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      n_fail++; $display("FAIL lb_req: got a=%h be=%b we=%b want 200 1111 0",
                         obs_addr, obs_be, obs_we);
    end
    run_op(1, 0, 3'b100, 32'h0000_0202, 32'h0, 5'd8, 1, 0, 32'h11F0_7733);
    n_checks++;
    if (obs_wb_valid !== 1'b1 || obs_wb_data !== 32'h0000_00F0 || obs_wb_rd !== 5'd8) begin
      n_fail++; $display("FAIL lbu: got v=%b d=%h rd=%0d want 1 000000f0 8",
                         obs_wb_valid, obs_wb_data, obs_wb_rd);
    end
  endtask

  task automatic test_fault;
    logic [31:0] addrs [4] = '{32'h301, 32'h402, 32'h10, 32'h20};
    logic [2:0]  f3s   [4] = '{3'b001, 3'b010, 3'b011, 3'b000};
    logic        mrs   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        mws   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op(mrs[i], mws[i], f3s[i], addrs[i], 32'h1234_5678, 5'd3, 0, 0, 32'h0);
      n_checks++;
      if (obs_fault !== 1'b1 || obs_req_seen !== 1'b0 || obs_wb_valid !== 1'b0 ||
          obs_extra !== 1'b0 || obs_ready_end !== 1'b1) begin
        n_fail++; $display("FAIL fault_%0d: f=%b req=%b wb=%b extra=%b rdy=%b want 1 0 0 0 1",
                           i, obs_fault, obs_req_seen, obs_wb_valid, obs_extra, obs_ready_end);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic busy_ok = 1'b1;
    ex_valid = 1; MemRead = 1; MemWrite = 0; funct3 = 3'b010; ALUout = 32'h500; rd_in = 5'd9;
    tick();
    ex_valid = 0; busy_ok &= !ex_ready; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin busy_ok &= !ex_ready; tick(); end
    busy_ok &= !ex_ready; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 0;
    n_checks++;
    if (busy_ok !== 1'b1 || wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_rd !== 5'd9 ||
        ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL lw_b2b: busy=%b v=%b d=%h rd=%0d rdy=%b want 1 1 deadbeef 9 1",
                         busy_ok, wb_valid, wb_data, wb_rd, ex_ready);
    end
    ex_valid = 1; MemRead = 0; ALUout = 32'hCAFE; rd_in = 5'd12;
    tick();
    ex_valid = 0;
    n_checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE || wb_rd !== 5'd12) begin
      n_fail++; $display("FAIL pass_after_lw: v=%b d=%h rd=%0d want 1 0000cafe 12",
                         wb_valid, wb_data, wb_rd);
    end
    ex_valid = 1; MemWrite = 1; funct3 = 3'b010; ALUout = 32'h600; WriteData = 32'h0102_0304;
    tick();
    ex_valid = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    n_checks++;
    if (store_done !== 1'b1 || ex_ready !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL sw_2cyc: done=%b rdy=%b req=%b want 1 1 0",
                         store_done, ex_ready, mem_req);
    end
    ex_valid = 1; funct3 = 3'b000; ALUout = 32'h601; WriteData = 32'h0000_00A5;
    tick();
    ex_valid = 0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL sb_after_sw: req=%b be=%b wd=%h want 1 0010 a5a5a5a5",
                         mem_req, mem_be, mem_wdata);
    end
    mem_gnt = 1;
    tick();
    mem_gnt = 0; MemWrite = 0;
    tick();
  endtask

  task automatic test_random;
    int          kind, r;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_lv, addr, wd, rdata;
    logic [2:0]  f3;
    logic        mr, mw;
    logic [4:0]  rd;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 3));
      mr = (r == 1) || (r == 3 && $urandom_range(0, 3) == 0);
      mw = (r == 2) || (r == 3 && !mr);
      f3 = 3'($urandom); addr = $urandom; wd = $urandom; rdata = $urandom; rd = 5'($urandom);
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      model(mr, mw, f3, addr, wd, rdata, kind, e_be, e_wd, e_lv);
      run_op(mr, mw, f3, addr, wd, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             rdata);
      n_checks++;
      if (obs_fault !== (kind == 1) || obs_store_done !== (kind == 2) ||
          obs_wb_valid !== (kind == 0 || kind == 3) || obs_extra !== 1'b0) begin
        n_fail++; $display("FAIL rnd_pulses[%0d]: f=%b sd=%b wb=%b extra=%b kind=%0d",
                           n, obs_fault, obs_store_done, obs_wb_valid, obs_extra, kind);
      end
      if (kind == 0 || kind == 3) begin
        n_checks++;
        if (obs_wb_data !== (kind == 0 ? addr : e_lv) || obs_wb_rd !== rd) begin
          n_fail++; $display("FAIL rnd_wb[%0d]: got %h rd=%0d want %h rd=%0d", n, obs_wb_data,
                             obs_wb_rd, (kind == 0 ? addr : e_lv), rd);
        end
      end
      if (kind >= 2) begin
        n_checks++;
        if (obs_addr !== {addr[31:2], 2'b00} || obs_be !== e_be || obs_wdata !== e_wd ||
            obs_we !== (kind == 2) || obs_hold_ok !== 1'b1 || obs_busy_ok !== 1'b1 ||
            obs_req_after !== 1'b0) begin
          n_fail++; $display("FAIL rnd_mem[%0d]: a=%h be=%b wd=%h we=%b hold=%b busy=%b want %h %b %h",
                             n, obs_addr, obs_be, obs_wdata, obs_we, obs_hold_ok, obs_busy_ok,
                             {addr[31:2], 2'b00}, e_be, e_wd);
        end
      end else begin
        n_checks++;
        if (obs_req_seen !== 1'b0 || obs_ready_end !== 1'b1) begin
          n_fail++; $display("FAIL rnd_noreq[%0d]: req=%b rdy=%b want 0 1",
                             n, obs_req_seen, obs_ready_end);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic stale = 1'b0;
    ex_valid = 1; MemRead = 1; MemWrite = 0; funct3 = 3'b010; ALUout = 32'h10; rd_in = 5'd3;
    tick();
    ex_valid = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_data, wb_rd,
         store_done, fault} !== '0 || ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: addr=%h be=%b wb=%h rdy=%b want all 0, rdy 1",
                         mem_addr, mem_be, wb_data, ex_ready);
    end
    tick();
    rst_n = 1'b1; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin stale |= wb_valid | !ex_ready; tick(); end
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL stale_rvalid: got wb/busy activity %b want 0", stale);
    end
  endtask

  initial begin
    ex_valid = 0; MemRead = 0; MemWrite = 0; funct3 = '0; ALUout = '0; WriteData = '0;
    rd_in = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    test_reset();
    test_passthrough();
    test_store_byte();
    test_load_ext();
    test_fault();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
